audio_dac_tx: RTL and testbench

Transmit half of the audio CODEC data path. It accepts stereo sample pairs from the processing chain through a read/write-style handshake (`write`, `write_ready`, 24-bit left/right words) and buffers them in a small FIFO. It serializes them MSB-first onto `AUD_DACDAT` in I2S format, framed by the CODEC-mastered `AUD_BCLK` and `AUD_DACLRCK`. The block sits between the filter/noise datapath and the CODEC pins, in place of the DAC half of the vendor codec core.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/audio_dac_tx_if.sv | 27 ++
 rtl/sample_fifo.sv | 77 +++++++
 rtl/audio_dac_tx.sv | 138 +++++++++++++
 tb/tb_audio_dac_tx.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC transmit path.
package audio_pkg;

  localparam int AUDIO_DATA_WIDTH = 24;
  localparam int AUDIO_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic [AUDIO_DATA_WIDTH-1:0] left;
    logic [AUDIO_DATA_WIDTH-1:0] right;
  } stereo_sample_t;

  // Width of an occupancy counter that must be able to hold the value depth itself.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/audio_dac_tx_if.sv
// Sample write handshake between the processing chain and the DAC transmitter.
interface audio_dac_tx_if
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH
);

  logic                  write;
  logic [DATA_WIDTH-1:0] writedata_left;
  logic [DATA_WIDTH-1:0] writedata_right;
  logic                  write_ready;

  modport master (
    output write,
    output writedata_left,
    output writedata_right,
    input  write_ready
  );

  modport slave (
    input  write,
    input  writedata_left,
    input  writedata_right,
    output write_ready
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO of stereo pairs; ready_o is a registered not-full flag that is
// held low during reset. Pushes are gated by ready_o, pops by empty.
module sample_fifo
  import audio_pkg::*;
#(
  parameter  int WIDTH = 2 * AUDIO_DATA_WIDTH,
  parameter  int DEPTH = AUDIO_FIFO_DEPTH,
  localparam int LVL_W = level_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             ready_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             ready_q;
  logic             push_s;
  logic             pop_s;

  assign push_s  = push_i && ready_q;
  assign pop_s   = pop_i && (level_q != LVL_W'(0));
  assign rdata_o = mem_q[rd_ptr_q];
  assign ready_o = ready_q;
  assign empty_o = (level_q == LVL_W'(0));
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    level_d = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers, level and ready flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      ready_q <= (level_d != LVL_W'(DEPTH));
    end
  end

endmodule

// File: rtl/audio_dac_tx.sv
// I2S DAC transmitter: buffers stereo pairs and shifts them MSB-first onto AUD_DACDAT,
// slaved to the CODEC's BCLK/LRCK, which are resynchronised into CLOCK_50.
module audio_dac_tx
  import audio_pkg::*;
#(
  parameter  int DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter  int FIFO_DEPTH = AUDIO_FIFO_DEPTH,
  localparam int LVL_W      = level_width(FIFO_DEPTH)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  audio_dac_tx_if.slave    wr_if,
  output logic [LVL_W-1:0] fifo_level,
  output logic             underrun,
  input  logic             AUD_BCLK,
  input  logic             AUD_DACLRCK,
  output logic             AUD_DACDAT
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [1:0]              bclk_sync_q;
  logic [1:0]              lrck_sync_q;
  logic                    bclk_prev_q;
  logic                    bfall_q;
  logic                    lrck_s;

  tx_state_t               state_q;
  logic                    lrck_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   right_hold_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic                    dacdat_q;
  logic                    underrun_q;

  logic                    frame_start_s;
  logic                    left_start_s;
  logic                    right_start_s;
  logic                    fifo_empty_s;
  logic                    fifo_full_s;
  logic                    fifo_ready_s;
  logic [2*DATA_WIDTH-1:0] fifo_rdata_s;

  sample_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .push_i  (wr_if.write),
    .pop_i   (left_start_s),
    .wdata_i ({wr_if.writedata_left, wr_if.writedata_right}),
    .rdata_o (fifo_rdata_s),
    .ready_o (fifo_ready_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s),
    .level_o (fifo_level)
  );

  assign wr_if.write_ready = fifo_ready_s;

  // Synchronise the CODEC clocks and turn a BCLK fall into a registered one-cycle strobe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_sync_q <= 2'b00;
      lrck_sync_q <= 2'b00;
      bclk_prev_q <= 1'b0;
      bfall_q     <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[0], AUD_DACLRCK};
      bclk_prev_q <= bclk_sync_q[1];
      bfall_q     <= bclk_prev_q & ~bclk_sync_q[1];
    end
  end

  // An LRCK change seen on a BCLK fall starts a half-frame; loading here and shifting
  // from the next fall yields the one-bit I2S delay.
  assign lrck_s        = lrck_sync_q[1];
  assign frame_start_s = bfall_q && (lrck_s != lrck_q);
  assign left_start_s  = frame_start_s && !lrck_s;
  assign right_start_s = frame_start_s && lrck_s;

  // Framing FSM, serializer and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= WAIT_SYNC;
      lrck_q       <= 1'b0;
      shreg_q      <= '0;
      right_hold_q <= '0;
      bit_cnt_q    <= '0;
      dacdat_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      underrun_q <= left_start_s && fifo_empty_s;
      if (bfall_q) begin
        lrck_q <= lrck_s;
        if (left_start_s) begin
          state_q   <= LEFT;
          bit_cnt_q <= '0;
          dacdat_q  <= 1'b0;
          if (!fifo_empty_s) begin
            shreg_q      <= fifo_rdata_s[2*DATA_WIDTH-1:DATA_WIDTH];
            right_hold_q <= fifo_rdata_s[DATA_WIDTH-1:0];
          end else begin
            shreg_q      <= '0;
            right_hold_q <= '0;
          end
        end else if (right_start_s && (state_q != WAIT_SYNC)) begin
          state_q   <= RIGHT;
          shreg_q   <= right_hold_q;
          bit_cnt_q <= '0;
          dacdat_q  <= 1'b0;
        end else begin
          case (state_q)
            LEFT, RIGHT: begin
              if (bit_cnt_q != CNT_W'(DATA_WIDTH)) begin
                dacdat_q  <= shreg_q[DATA_WIDTH-1];
                shreg_q   <= {shreg_q[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end else begin
                dacdat_q <= 1'b0;
              end
            end
            default: begin
              state_q  <= WAIT_SYNC;
              dacdat_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign AUD_DACDAT = dacdat_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx: drives BCLK/LRCK slot by slot (16 CLOCK_50 per bit,
// 32 bits per half-frame) and checks each half-frame's serial word and underrun count.
module tb_audio_dac_tx;
  import audio_pkg::*;

  logic       CLOCK_50    = 1'b0;
  logic       reset       = 1'b1;
  logic       AUD_BCLK    = 1'b1;
  logic       AUD_DACLRCK = 1'b1;
  logic       AUD_DACDAT;
  logic       underrun;
  logic [2:0] fifo_level;

  int vectors     = 0;
  int miscompares = 0;

  audio_dac_tx_if #(.DATA_WIDTH(24)) wr_if ();

  audio_dac_tx #(
    .DATA_WIDTH (24),
    .FIFO_DEPTH (4)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .wr_if       (wr_if),
    .fifo_level  (fifo_level),
    .underrun    (underrun),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One BCLK period starting at its falling edge; optionally pushes in the bfall cycle.
  task automatic bit_slot(input logic lr, input logic do_wr, input stereo_sample_t p,
                          output logic d, output logic u);
    AUD_BCLK    = 1'b0;
    AUD_DACLRCK = lr;
    repeat (3) @(negedge CLOCK_50);
    if (do_wr) begin
      wr_if.write           = 1'b1;
      wr_if.writedata_left  = p.left;
      wr_if.writedata_right = p.right;
    end
    @(negedge CLOCK_50);
    wr_if.write = 1'b0;
    u = underrun;
    repeat (3) @(negedge CLOCK_50);
    d = AUD_DACDAT;
    @(negedge CLOCK_50);
    AUD_BCLK = 1'b1;
    repeat (8) @(negedge CLOCK_50);
  endtask

  task automatic run_half(input logic lr, input logic do_wr, input stereo_sample_t p,
                          output logic [31:0] bits, output int ups);
    logic d;
    logic u;
    bits = 32'h0;
    ups  = 0;
    for (int i = 0; i < 32; i++) begin
      bit_slot(lr, do_wr && (i == 0), p, d, u);
      bits = {bits[30:0], d};
      ups  = ups + int'(u);
    end
  endtask

  task automatic check_half(input string tag, input logic lr, input logic [23:0] word,
                            input int exp_ups);
    logic [31:0] bits;
    int          ups;
    run_half(lr, 1'b0, '0, bits, ups);
    check({tag, "_bits"}, bits, {1'b0, word, 7'b0000000});
    check({tag, "_underruns"}, 32'(ups), 32'(exp_ups));
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    wr_if.write           = 1'b1;
    wr_if.writedata_left  = l;
    wr_if.writedata_right = r;
    @(negedge CLOCK_50);
    wr_if.write = 1'b0;
  endtask

  initial begin
    stereo_sample_t pairs [5];
    stereo_sample_t p5;
    logic [31:0]    bits;
    int             ups;
    logic           d;
    logic           u;

    wr_if.write           = 1'b0;
    wr_if.writedata_left  = 24'h000000;
    wr_if.writedata_right = 24'h000000;

    // 1. reset values
    repeat (5) @(negedge CLOCK_50);
    check("rst_write_ready", 32'(wr_if.write_ready), 32'h0);
    check("rst_dacdat", 32'(AUD_DACDAT), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("rel_write_ready", 32'(wr_if.write_ready), 32'h1);

    // 2. single pair; two LRCK-high slots first so the LRCK fall is seen as an edge
    push(24'hA5A5A5, 24'h800001);
    check("t2_level_push", 32'(fifo_level), 32'h1);
    for (int i = 0; i < 2; i++) begin
      bit_slot(1'b1, 1'b0, '0, d, u);
    end
    check("t2_preamble_dacdat", 32'(d), 32'h0);
    check_half("t2_left", 1'b0, 24'hA5A5A5, 0);
    check_half("t2_right", 1'b1, 24'h800001, 0);
    check("t2_level_after", 32'(fifo_level), 32'h0);

    // 3. fill and drop: five back-to-back writes, the fifth must be dropped
    pairs[0] = '{left: 24'h111111, right: 24'hEEEEEE};
    pairs[1] = '{left: 24'h2468AC, right: 24'hFEDCBA};
    pairs[2] = '{left: 24'h800000, right: 24'h7FFFFF};
    pairs[3] = '{left: 24'h0F0F0F, right: 24'hF0F0F0};
    pairs[4] = '{left: 24'hDEAD00, right: 24'hBEEF00};
    for (int i = 0; i < 5; i++) begin
      wr_if.write           = 1'b1;
      wr_if.writedata_left  = pairs[i].left;
      wr_if.writedata_right = pairs[i].right;
      @(negedge CLOCK_50);
      if (i == 3) begin
        check("t3_ready_after_4th", 32'(wr_if.write_ready), 32'h0);
      end
    end
    wr_if.write = 1'b0;
    check("t3_level_full", 32'(fifo_level), 32'h4);
    @(negedge CLOCK_50);
    check("t3_ready_full", 32'(wr_if.write_ready), 32'h0);
    check("t3_level_hold", 32'(fifo_level), 32'h4);
    for (int i = 0; i < 4; i++) begin
      check_half($sformatf("t3_left%0d", i), 1'b0, pairs[i].left, 0);
      check_half($sformatf("t3_right%0d", i), 1'b1, pairs[i].right, 0);
    end
    check("t3_level_drained", 32'(fifo_level), 32'h0);

    // 4. underrun: two frames with nothing buffered (fifth pair must not appear)
    for (int f = 0; f < 2; f++) begin
      check_half($sformatf("t4_left%0d", f), 1'b0, 24'h000000, 1);
      check_half($sformatf("t4_right%0d", f), 1'b1, 24'h000000, 0);
    end

    // 5. push exactly in the left-start bfall cycle with the FIFO empty
    p5 = '{left: 24'h000001, right: 24'h7FFFFF};
    run_half(1'b0, 1'b1, p5, bits, ups);
    check("t5_left_bits", bits, 32'h0);
    check("t5_left_underruns", 32'(ups), 32'h1);
    check("t5_level", 32'(fifo_level), 32'h1);
    check_half("t5_right", 1'b1, 24'h000000, 0);
    check_half("t5_next_left", 1'b0, 24'h000001, 0);
    check_half("t5_next_right", 1'b1, 24'h7FFFFF, 0);

    // 6. reset after 10 bits of the left word
    push(24'hFFFFFF, 24'h123456);
    for (int i = 0; i < 11; i++) begin
      bit_slot(1'b0, 1'b0, '0, d, u);
    end
    check("t6_bit10_before_reset", 32'(d), 32'h1);
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("t6_rst_dacdat", 32'(AUD_DACDAT), 32'h0);
    check("t6_rst_level", 32'(fifo_level), 32'h0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    push(24'hC0FFEE, 24'h5A5A5A);
    bits = 32'h0;
    ups  = 0;
    for (int i = 0; i < 21; i++) begin
      bit_slot(1'b0, 1'b0, '0, d, u);
      bits = {bits[30:0], d};
      ups  = ups + int'(u);
    end
    check("t6_left_tail_bits", bits, 32'h0);
    check("t6_left_tail_underruns", 32'(ups), 32'h0);
    check_half("t6_right_ignored", 1'b1, 24'h000000, 0);
    check("t6_level_waiting", 32'(fifo_level), 32'h1);
    check_half("t6_left", 1'b0, 24'hC0FFEE, 0);
    check_half("t6_right", 1'b1, 24'h5A5A5A, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
